// File: rtl/quad_ts_byte_fifo.sv
// rtl/quad_ts_byte_fifo.sv - four independent 16-deep TS byte FIFOs with registered pop outputs
// Optional FIFO_OVERWRITE_EN: a write to a full channel discards the oldest byte instead of being dropped.
module quad_ts_byte_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] wdata1,
  input  logic [DATA_WIDTH-1:0] wdata2,
  input  logic [DATA_WIDTH-1:0] wdata3,
  input  logic [DATA_WIDTH-1:0] wdata4,
  input  logic                  valid1,
  input  logic                  valid2,
  input  logic                  valid3,
  input  logic                  valid4,
  input  logic                  ready1,
  input  logic                  ready2,
  input  logic                  ready3,
  input  logic                  ready4,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [DATA_WIDTH-1:0] rdata2,
  output logic [DATA_WIDTH-1:0] rdata3,
  output logic [DATA_WIDTH-1:0] rdata4,
  output logic                  valid_out1,
  output logic                  valid_out2,
  output logic                  valid_out3,
  output logic                  valid_out4,
  output logic                  full1,
  output logic                  full2,
  output logic                  full3,
  output logic                  full4,
  output logic                  empty1,
  output logic                  empty2,
  output logic                  empty3,
  output logic                  empty4
);

  localparam int DEPTH_I = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [DATA_WIDTH-1:0] wdata_a [4];
  logic [3:0]            valid_a;
  logic [3:0]            ready_a;

  assign wdata_a[0] = wdata1;
  assign wdata_a[1] = wdata2;
  assign wdata_a[2] = wdata3;
  assign wdata_a[3] = wdata4;
  assign valid_a    = {valid4, valid3, valid2, valid1};
  assign ready_a    = {ready4, ready3, ready2, ready1};

  for (genvar g = 0; g < 4; g++) begin : g_ch
    logic [DATA_WIDTH-1:0] mem [DEPTH_I];
    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] rptr;
    logic [ADDR_WIDTH:0]   count;
    logic [ADDR_WIDTH:0]   count_nxt;
    logic [DATA_WIDTH-1:0] rdata_r;
    logic                  vout_r;
    logic                  full_r;
    logic                  empty_r;
    logic                  pop;
    logic                  push;
    logic                  drop_oldest;

    always_comb begin
      pop         = ready_a[g] && (count != '0);
      push        = valid_a[g] && ((count != DEPTH) || pop);
      drop_oldest = 1'b0;
`ifdef FIFO_OVERWRITE_EN
      // Full with no pop: retire the oldest entry so the new byte still lands.
      drop_oldest = valid_a[g] && !pop && (count == DEPTH);
      push        = push || drop_oldest;
`endif
      count_nxt = count;
      if (push && !pop && !drop_oldest) begin
        count_nxt = count + 1'b1;
      end else if (pop && !push) begin
        count_nxt = count - 1'b1;
      end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
      if (push) begin
        mem[wptr] <= wdata_a[g];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wptr    <= '0;
        rptr    <= '0;
        count   <= '0;
        rdata_r <= '0;
        vout_r  <= 1'b0;
        full_r  <= 1'b0;
        empty_r <= 1'b1;
      end else begin
        vout_r <= pop;
        if (pop) begin
          rdata_r <= mem[rptr];
        end
        if (pop || drop_oldest) begin
          rptr <= rptr + 1'b1;
        end
        if (push) begin
          wptr <= wptr + 1'b1;
        end
        count   <= count_nxt;
        full_r  <= (count_nxt == DEPTH);
        empty_r <= (count_nxt == '0);
      end
    end
  end

  assign rdata1     = g_ch[0].rdata_r;
  assign rdata2     = g_ch[1].rdata_r;
  assign rdata3     = g_ch[2].rdata_r;
  assign rdata4     = g_ch[3].rdata_r;
  assign valid_out1 = g_ch[0].vout_r;
  assign valid_out2 = g_ch[1].vout_r;
  assign valid_out3 = g_ch[2].vout_r;
  assign valid_out4 = g_ch[3].vout_r;
  assign full1      = g_ch[0].full_r;
  assign full2      = g_ch[1].full_r;
  assign full3      = g_ch[2].full_r;
  assign full4      = g_ch[3].full_r;
  assign empty1     = g_ch[0].empty_r;
  assign empty2     = g_ch[1].empty_r;
  assign empty3     = g_ch[2].empty_r;
  assign empty4     = g_ch[3].empty_r;

endmodule

// File: tb/tb_quad_ts_byte_fifo.sv
// tb/tb_quad_ts_byte_fifo.sv - queue-model bench for quad_ts_byte_fifo
module tb_quad_ts_byte_fifo;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [3:0][7:0] wd;
  logic [3:0]      vld;
  logic [3:0]      rdy;
  logic [3:0][7:0] rd;
  logic [3:0]      vo;
  logic [3:0]      fu;
  logic [3:0]      em;

  int tests = 0;
  int fails = 0;
  bit check_en = 1'b0;
  int edge_cnt = 0;

  logic [7:0] q [4][$];
  logic [7:0] m_rd [4];
  logic       m_vo [4];
  logic [7:0] log_d [4][$];
  int         log_t [4][$];

  always #5 clk = ~clk;

  quad_ts_byte_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .wdata1(wd[0]), .wdata2(wd[1]), .wdata3(wd[2]), .wdata4(wd[3]),
    .valid1(vld[0]), .valid2(vld[1]), .valid3(vld[2]), .valid4(vld[3]),
    .ready1(rdy[0]), .ready2(rdy[1]), .ready3(rdy[2]), .ready4(rdy[3]),
    .rdata1(rd[0]), .rdata2(rd[1]), .rdata3(rd[2]), .rdata4(rd[3]),
    .valid_out1(vo[0]), .valid_out2(vo[1]), .valid_out3(vo[2]), .valid_out4(vo[3]),
    .full1(fu[0]), .full2(fu[1]), .full3(fu[2]), .full4(fu[3]),
    .empty1(em[0]), .empty2(em[1]), .empty3(em[2]), .empty4(em[3])
  );

  // Reference: each channel is a plain queue; pop from the front, then append.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 4; c++) begin
        q[c].delete();
        m_rd[c] = 8'h00;
        m_vo[c] = 1'b0;
      end
    end else begin
      edge_cnt++;
      for (int c = 0; c < 4; c++) begin
        int n;
        bit p;
        n = q[c].size();
        p = rdy[c] && (n > 0);
        m_vo[c] = p;
        if (p) m_rd[c] = q[c].pop_front();
        if (vld[c]) begin
          if (n < 16 || p) begin
            q[c].push_back(wd[c]);
          end else begin
`ifdef FIFO_OVERWRITE_EN
            void'(q[c].pop_front());
            q[c].push_back(wd[c]);
`endif
          end
        end
      end
    end
  end

  task automatic check(input string nm, input int ch, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s ch%0d: got %0h expected %0h at edge %0d", nm, ch + 1, act, exp, edge_cnt);
    end
  endtask

  always @(negedge clk) begin
    if (check_en && rst_n) begin
      for (int c = 0; c < 4; c++) begin
        check("valid_out", c, 32'(vo[c]), 32'(m_vo[c]));
        check("rdata", c, 32'(rd[c]), 32'(m_rd[c]));
        check("full", c, 32'(fu[c]), 32'(q[c].size() == 16));
        check("empty", c, 32'(em[c]), 32'(q[c].size() == 0));
        if (vo[c]) begin
          log_d[c].push_back(rd[c]);
          log_t[c].push_back(edge_cnt);
        end
      end
    end
  end

  task automatic check_log(input string nm, input int ch, input logic [7:0] e[$]);
    check({nm, "_len"}, ch, 32'(log_d[ch].size()), 32'(e.size()));
    for (int i = 0; i < e.size() && i < log_d[ch].size(); i++) begin
      check(nm, ch, 32'(log_d[ch][i]), 32'(e[i]));
    end
  endtask

  task automatic clear_logs();
    for (int c = 0; c < 4; c++) begin
      log_d[c].delete();
      log_t[c].delete();
    end
  endtask

  task automatic reset_literals(input string nm);
    check({nm, "_rdata"}, 0, 32'(rd), 32'h0);
    check({nm, "_valid_out"}, 0, 32'(vo), 32'h0);
    check({nm, "_full"}, 0, 32'(fu), 32'h0);
    check({nm, "_empty"}, 0, 32'(em), 32'hF);
  endtask

  initial begin
    logic [7:0] e[$];
    int k;
    int pv;
    int pr;
    rst_n = 1'b0;
    wd = '0;
    vld = '0;
    rdy = '0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    reset_literals("reset");
    check_en = 1'b1;

    // Latency and order on channel 1
    clear_logs();
    k = edge_cnt + 1;
    rdy[0] = 1'b1;
    e = '{8'h47, 8'h1F, 8'hFF};
    for (int i = 0; i < 3; i++) begin
      vld[0] = 1'b1;
      wd[0] = e[i];
      @(negedge clk);
    end
    vld[0] = 1'b0;
    repeat (4) @(negedge clk);
    check_log("lat_data", 0, e);
    if (log_t[0].size() == 3) begin
      check("lat_first_edge", 0, 32'(log_t[0][0]), 32'(k + 1));
      check("lat_last_edge", 0, 32'(log_t[0][2]), 32'(k + 3));
    end else begin
      check("lat_count", 0, 32'(log_t[0].size()), 32'd3);
    end
    check("idle_others_empty", 1, 32'(em[3:1]), 32'h7);
    rdy[0] = 1'b0;

    // Fill channel 2, then an extra write while full
    clear_logs();
    for (int i = 0; i < 16; i++) begin
      vld[1] = 1'b1;
      wd[1] = 8'(i);
      @(negedge clk);
    end
    check("fill_full", 1, 32'(fu[1]), 32'h1);
    wd[1] = 8'hAA;
    @(negedge clk);
    vld[1] = 1'b0;
    check("full_write_full", 1, 32'(fu[1]), 32'h1);
    rdy[1] = 1'b1;
    repeat (20) @(negedge clk);
    e.delete();
`ifdef FIFO_OVERWRITE_EN
    for (int i = 1; i < 16; i++) e.push_back(8'(i));
    e.push_back(8'hAA);
`else
    for (int i = 0; i < 16; i++) e.push_back(8'(i));
`endif
    check_log("fill_drain", 1, e);
    check("drain_empty", 1, 32'(em[1]), 32'h1);
    check("drain_vout", 1, 32'(vo[1]), 32'h0);
    rdy[1] = 1'b0;

    // Full channel 3 with simultaneous push and pop
    clear_logs();
    for (int i = 0; i < 16; i++) begin
      vld[2] = 1'b1;
      wd[2] = 8'(i);
      @(negedge clk);
    end
    rdy[2] = 1'b1;
    wd[2] = 8'h55;
    @(negedge clk);
    vld[2] = 1'b0;
    check("pushpop_full", 2, 32'(fu[2]), 32'h1);
    check("pushpop_vout", 2, 32'(vo[2]), 32'h1);
    check("pushpop_rdata", 2, 32'(rd[2]), 32'h00);
    repeat (20) @(negedge clk);
    e.delete();
    for (int i = 0; i < 16; i++) e.push_back(8'(i));
    e.push_back(8'h55);
    check_log("pushpop_drain", 2, e);
    rdy[2] = 1'b0;

    // Streaming 40 bytes through channel 4 (pointer wraps twice)
    clear_logs();
    rdy[3] = 1'b1;
    e.delete();
    for (int i = 0; i < 40; i++) begin
      vld[3] = 1'b1;
      wd[3] = 8'(8'h80 + i);
      e.push_back(8'(8'h80 + i));
      @(negedge clk);
    end
    vld[3] = 1'b0;
    repeat (4) @(negedge clk);
    check_log("wrap_data", 3, e);
    if (log_t[3].size() == 40) begin
      check("wrap_no_gap", 3, 32'(log_t[3][39] - log_t[3][0]), 32'd39);
    end
    rdy[3] = 1'b0;

    // Randomized traffic with varying fill pressure and one async reset
    for (int seg = 0; seg < 6; seg++) begin
      pv = (seg % 2 == 0) ? 85 : 40;
      pr = (seg % 3 == 0) ? 20 : 75;
      for (int n = 0; n < 400; n++) begin
        for (int c = 0; c < 4; c++) begin
          vld[c] = ($urandom_range(0, 99) < pv);
          rdy[c] = ($urandom_range(0, 99) < pr);
          wd[c] = 8'($urandom);
        end
        if (seg == 3 && n == 200) begin
          #2 rst_n = 1'b0;
          #1 reset_literals("async_reset");
          @(negedge clk);
          #2 rst_n = 1'b1;
        end
        @(negedge clk);
      end
    end

    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/quad_ts_byte_fifo.md
Name: quad_ts_byte_fifo

Overview:
- Four independent, identical synchronous byte FIFOs in one block, one per MPEG-2 TS input stream.
- Sits between the TS byte sources (stimulus or upstream parsers) and downstream per-stream consumers.
- Each channel accepts one byte per cycle when its write-valid is high.
- Each channel automatically presents stored bytes on a registered output with a valid strobe whenever its consumer is ready.

Parameters:
- DATA_WIDTH, 8, width of each data word (one TS byte).
- ADDR_WIDTH, 4, pointer width; depth per channel = 2**ADDR_WIDTH (16).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wdata1..wdata4  in  DATA_WIDTH each  write data, channel n.
- valid1..valid4  in  1 each  write request, channel n.
- ready1..ready4  in  1 each  consumer ready, channel n; enables a pop.
- rdata1..rdata4  out  DATA_WIDTH each  registered read data, channel n.
- valid_out1..valid_out4  out  1 each  rdata_n valid for exactly this cycle.
- full1..full4  out  1 each  channel holds 2**ADDR_WIDTH entries.
- empty1..empty4  out  1 each  channel holds 0 entries.

Behaviour:
- Channels are fully independent. No signal of one channel affects another.
- Per channel, state is: memory [2**ADDR_WIDTH x DATA_WIDTH], write pointer, read pointer (ADDR_WIDTH bits, wrap modulo depth), and an ADDR_WIDTH+1 bit occupancy count.
- Reset (rst_n low, asynchronous): pointers=0, count=0, rdata=0, valid_out=0, full=0, empty=1. Memory contents are not reset. Reset may assert mid-operation; all stored data is discarded immediately.
- pop = ready_n AND (count>0), evaluated on pre-edge state. On a pop edge: rdata_n <= mem[rptr], valid_out_n <= 1, rptr increments.
- On a non-pop edge: valid_out_n <= 0 and rdata_n holds its last value.
- push = valid_n AND (count<depth OR pop). On a push edge: mem[wptr] <= wdata_n, wptr increments.
- A write while full is accepted if the same edge pops.
- A write while full without a pop is dropped; no state changes.
- count: +1 on push only, -1 on pop only, unchanged on both or neither.
- No write-to-read bypass. Earliest latency: valid_n high at edge k into an empty channel with ready high gives valid_out_n high in the cycle after edge k+1 (2 edges).
- Steady streaming (valid and ready high every cycle) gives one output per cycle. Data order is strictly FIFO.
- full_n and empty_n are registered and derived from the post-edge count. They are exact in the same cycle the count changes.
- Pointer wrap at 2**ADDR_WIDTH-1 -> 0 is transparent to the data order.

Optional Feature:
- Macro FIFO_OVERWRITE_EN.
- Defined: a write to a full channel with no pop is never dropped. The oldest entry is discarded (rptr increments), the new byte is written at wptr (wptr increments), count stays at depth, and valid_out/rdata are unaffected that edge.
- Not defined: writes to a full channel without a simultaneous pop are dropped as described in Behaviour.

Test Plan:
- Reset check: hold rst_n low, then release with all inputs 0 -> all rdata=0, valid_out=0, full=0, empty=1. Assert rst_n low asynchronously mid-stream -> outputs return to reset values before the next clk edge.
- Latency and order: ready1=1; write 0x47,0x1F,0xFF on consecutive edges -> valid_out1 high for 3 consecutive cycles carrying 0x47,0x1F,0xFF. The first valid_out1 appears 2 edges after the 0x47 write. Channels 2-4 remain idle and empty.
- Fill to full: ready2=0; write 0x00..0x0F (16 bytes) -> full2=1 after the 16th edge. Write 0xAA -> dropped (overwrite macro undefined). Raise ready2 -> outputs 0x00..0x0F, then valid_out2=0 and empty2=1.
- Full with simultaneous push/pop: channel 3 full with 0x00..0x0F; ready3=1 and write 0x55 on the same edge -> 0x00 popped, 0x55 accepted, full3 stays 1. Later the drain ends ...0x0F,0x55.
- Wrap-around streaming: channel 4, ready4=1, write 40 incrementing bytes continuously -> 40 outputs in order with no gaps after the first. Pointers wrap twice without corruption.
- Overwrite (FIFO_OVERWRITE_EN defined): channel 1 full with 0x00..0x0F, ready1=0; write 0xAA -> draining yields 0x01..0x0F,0xAA.
